// File: rtl/seq_detect_ctrl.sv
// Round-robin feeder for a 1011 serial detector: shifts each granted word MSB-first, counts matches, returns a result.
// Latency: grant to res_valid is WORD_W+3 cycles. Back-to-back grants are spaced WORD_W+4 cycles apart.
// Backpressure: requests wait while busy; DONE holds its result until res_ready. SEQ_CTRL_FIRST_POS_EN adds res_first.
module seq_detect_ctrl #(
    parameter int WORD_W = 8,
    parameter int CNT_W  = 16,
    parameter int RES_W  = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [WORD_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WORD_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              det_rst,
    output logic              det_bit,
    input  logic              det_seen,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_id,
    output logic [RES_W-1:0]  res_count,
    output logic [CNT_W-1:0]  tot_matches,
`ifdef SEQ_CTRL_FIRST_POS_EN
    output logic [$clog2(WORD_W):0] res_first,
`endif
    output logic              busy
);

    localparam int IDX_W = $clog2(WORD_W);
    localparam int FP_W  = $clog2(WORD_W) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        SHIFT = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                last_grant_q, last_grant_d;
    logic                res_id_q, res_id_d;
    logic [RES_W-1:0]    res_count_q, res_count_d;
    logic [CNT_W-1:0]    tot_q, tot_d;
    logic [FP_W-1:0]     first_q, first_d;

    logic                grant_id;
    logic                sample;
    logic [FP_W-1:0]     sample_pos;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        idx_d        = idx_q;
        last_grant_d = last_grant_q;
        res_id_d     = res_id_q;
        res_count_d  = res_count_q;
        tot_d        = tot_q;
        first_d      = first_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        det_rst      = 1'b1;
        det_bit      = 1'b0;
        sample       = 1'b0;
        sample_pos   = '0;
        // Single requester wins outright; on a tie the one not served last goes.
        grant_id     = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

        case (state_q)
            IDLE: begin
                // Ready is gated by reset so nothing is acknowledged while held in reset.
                if (reset && (req0_valid || req1_valid)) begin
                    req0_ready   = ~grant_id;
                    req1_ready   = grant_id;
                    shreg_d      = grant_id ? req1_data : req0_data;
                    last_grant_d = grant_id;
                    res_id_d     = grant_id;
                    res_count_d  = '0;
                    first_d      = FP_W'(WORD_W);
                    idx_d        = '0;
                    state_d      = CLR;
                end
            end
            CLR: begin
                state_d = SHIFT;
            end
            SHIFT: begin
                det_rst    = 1'b0;
                det_bit    = shreg_q[WORD_W-1];
                shreg_d    = shreg_q << 1;
                idx_d      = idx_q + IDX_W'(1);
                // det_seen lags the bit that completed a match by one cycle.
                sample     = det_seen && (idx_q != '0);
                sample_pos = FP_W'(idx_q) - FP_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                det_rst    = 1'b0;
                sample     = det_seen;
                sample_pos = FP_W'(WORD_W - 1);
                state_d    = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (sample) begin
            res_count_d = res_count_q + RES_W'(1);
            tot_d       = (&tot_q) ? tot_q : tot_q + CNT_W'(1);
            if (first_q == FP_W'(WORD_W)) begin
                first_d = sample_pos;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            idx_q        <= '0;
            last_grant_q <= 1'b1;
            res_id_q     <= 1'b0;
            res_count_q  <= '0;
            tot_q        <= '0;
            first_q      <= '0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            idx_q        <= idx_d;
            last_grant_q <= last_grant_d;
            res_id_q     <= res_id_d;
            res_count_q  <= res_count_d;
            tot_q        <= tot_d;
            first_q      <= first_d;
        end
    end

    assign res_valid   = (state_q == DONE);
    assign res_id      = res_id_q;
    assign res_count   = res_count_q;
    assign tot_matches = tot_q;
    assign busy        = (state_q != IDLE);

`ifdef SEQ_CTRL_FIRST_POS_EN
    assign res_first = first_q;
`else
    logic unused_first;
    assign unused_first = ^first_q;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with a behavioural 1011 Moore detector attached.
module tb_seq_detect_ctrl;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        det_rst, det_bit, det_seen;
    logic        res_valid, res_ready, res_id;
    logic [3:0]  res_count;
    logic [15:0] tot_matches;
    logic        busy;
`ifdef SEQ_CTRL_FIRST_POS_EN
    logic [3:0]  res_first;
`endif

    int n_chk = 0;
    int n_err = 0;
    int exp_tot = 0;

    seq_detect_ctrl #(.WORD_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .det_rst     (det_rst),
        .det_bit     (det_bit),
        .det_seen    (det_seen),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_id      (res_id),
        .res_count   (res_count),
        .tot_matches (tot_matches),
`ifdef SEQ_CTRL_FIRST_POS_EN
        .res_first   (res_first),
`endif
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 1011 detector: registered Moore state, synchronous active-high reset, overlapping.
    logic [2:0] d_st;
    always_ff @(posedge clk) begin
        if (det_rst) d_st <= 3'd0;
        else begin
            case (d_st)
                3'd0:    d_st <= det_bit ? 3'd1 : 3'd0;
                3'd1:    d_st <= det_bit ? 3'd1 : 3'd2;
                3'd2:    d_st <= det_bit ? 3'd3 : 3'd0;
                3'd3:    d_st <= det_bit ? 3'd4 : 3'd2;
                default: d_st <= det_bit ? 3'd1 : 3'd2;
            endcase
        end
    end
    assign det_seen = (d_st == 3'd4);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns just after the grant edge.
    task automatic start_word(input bit id, input logic [7:0] d);
        if (id) begin req1_valid = 1'b1; req1_data = d; end
        else    begin req0_valid = 1'b1; req0_data = d; end
        #1;
        chk("grant_ready", id ? req1_ready : req0_ready, 1);
        chk("other_ready", id ? req0_ready : req1_ready, 0);
        @(posedge clk);
    endtask

    task automatic wait_res(input int exp_id, input int exp_cnt, input int exp_first);
        int lat;
        bit seen;
        lat  = 1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                #1 chk("ready_after_grant", {31'd0, req0_ready | req1_ready}, 0);
            end
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        exp_tot = exp_tot + exp_cnt;
        chk("res_seen", seen, 1);
        chk("latency", lat, 11);
        chk("res_id", res_id, exp_id);
        chk("res_count", res_count, exp_cnt);
        chk("tot_matches", tot_matches, exp_tot);
`ifdef SEQ_CTRL_FIRST_POS_EN
        chk("res_first", res_first, exp_first);
`else
        if (exp_first < 0) $display("note: negative first index %0d", exp_first);
`endif
    endtask

    task automatic finish_res();
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_valid_drop", res_valid, 0);
        chk("idle_after", busy, 0);
    endtask

    int exp_gid [3] = '{0, 1, 0};
    int exp_cnt [3] = '{1, 1, 1};
    int exp_fst [3] = '{3, 7, 3};

    initial begin
        int ngr, nres, rdy_cycles;
        reset = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        res_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_det_rst", det_rst, 1);
        chk("rst_det_bit", det_bit, 0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_tot", tot_matches, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Single words, including no-match patterns.
        start_word(0, 8'hB0); wait_res(0, 1, 3); finish_res();
        start_word(1, 8'hB6); wait_res(1, 2, 3); finish_res();
        start_word(0, 8'h00); wait_res(0, 0, 8); finish_res();
        start_word(1, 8'hFF); wait_res(1, 0, 8); finish_res();

        // Both requesters held valid for three words; 0B's match lands on the last bit.
        req0_valid = 1'b1; req0_data = 8'hB0;
        req1_valid = 1'b1; req1_data = 8'h0B;
        res_ready  = 1'b1;
        ngr = 0; nres = 0; rdy_cycles = 0;
        for (int cyc = 0; cyc < 200 && nres < 3; cyc++) begin
            #1;
            if (req0_ready || req1_ready) begin
                rdy_cycles++;
                chk("rr_gnt_idle", busy, 0);
                if (ngr < 3) chk("rr_gnt_id", req1_ready, exp_gid[ngr]);
                ngr++;
            end
            if (res_valid) begin
                if (nres < 3) begin
                    exp_tot = exp_tot + exp_cnt[nres];
                    chk("rr_res_id", res_id, exp_gid[nres]);
                    chk("rr_res_count", res_count, exp_cnt[nres]);
                    chk("rr_tot", tot_matches, exp_tot);
`ifdef SEQ_CTRL_FIRST_POS_EN
                    chk("rr_res_first", res_first, exp_fst[nres]);
`endif
                end
                nres++;
            end
            @(negedge clk);
            if (ngr >= 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
        end
        res_ready = 1'b0;
        chk("rr_ready_cycles", rdy_cycles, 3);
        chk("rr_results", nres, 3);
        if (exp_fst[0] != 3) $display("note: table edited");

        // Consumer stalls in DONE while the other requester waits.
        start_word(0, 8'hB6); wait_res(0, 2, 3);
        req1_valid = 1'b1; req1_data = 8'h00;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", res_valid, 1);
            chk("stall_id", res_id, 0);
            chk("stall_count", res_count, 2);
            chk("stall_no_grant", req1_ready, 0);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("stall_released", res_valid, 0);
        #1 chk("stall_next_grant", req1_ready, 1);
        @(posedge clk);
        wait_res(1, 0, 8); finish_res();

        // Reset in the middle of SHIFT discards the word.
        start_word(0, 8'hB6);
        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_tot = 0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_det_rst", det_rst, 1);
        chk("mid_rst_det_bit", det_bit, 0);
        chk("mid_rst_ready", req0_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_count", res_count, 0);
        chk("mid_rst_tot", tot_matches, 0);
        repeat (2) @(negedge clk);
        chk("mid_rst_hold_valid", res_valid, 0);
        reset = 1'b1;
        req0_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 0);
        start_word(1, 8'hB0); wait_res(1, 1, 3); finish_res();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
